cmp_serial_param: RTL and testbench

Parametrised, digit-serial magnitude comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, in either unsigned or two's-complement mode. A start/busy/done handshake controls each comparison, and an optional early-exit mode finishes on the first differing digit. It replaces fixed-width combinational comparators where width is large and area matters more than latency.

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/cmp_digit.sv | 41 ++++
 rtl/cmp_serial_param.sv | 142 ++++++++++++++
 tb/tb_cmp_serial_param.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
// Holds the FSM state encoding, the result encoding and the digit-index width helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } res_t;

  // A single-digit comparator still carries a 1-bit index register.
  function automatic int idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit magnitude comparator built as an XNOR chain.
// invert_msb flips the top bit of both operands so signed digits compare as offset binary.
module cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             invert_msb,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT-1:0] w_xnor;
  logic [DIGIT-1:0] w_hi_eq;
  logic [DIGIT-1:0] w_gt_bit;
  logic [DIGIT-1:0] w_lt_bit;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    if (i == DIGIT - 1) begin : g_top
      assign w_x[i]     = x[i] ^ invert_msb;
      assign w_y[i]     = y[i] ^ invert_msb;
      assign w_hi_eq[i] = 1'b1;
    end else begin : g_low
      assign w_x[i]     = x[i];
      assign w_y[i]     = y[i];
      // Bit i only decides when every more-significant bit matched.
      assign w_hi_eq[i] = &w_xnor[DIGIT-1:i+1];
    end
    assign w_xnor[i]   = ~(w_x[i] ^ w_y[i]);
    assign w_gt_bit[i] = w_hi_eq[i] & w_x[i] & ~w_y[i];
    assign w_lt_bit[i] = w_hi_eq[i] & ~w_x[i] & w_y[i];
  end

  assign eq = &w_xnor;
  assign gt = |w_gt_bit;
  assign lt = |w_lt_bit;

endmodule

// File: rtl/cmp_serial_param.sv
// Digit-serial WIDTH-bit magnitude comparator, MSB digit first, DIGIT bits per clock.
// start/busy/done handshake; optional early exit on the first differing digit.
module cmp_serial_param
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_is_equal,
  output logic             a_is_greater,
  output logic             a_is_smaller
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = idx_width(NDIG);
  localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

  if ((WIDTH < DIGIT) || (WIDTH % DIGIT != 0)) begin : g_bad_param
    $error("cmp_serial_param: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t                      r_state;
  state_t                      w_next;
  logic [NDIG-1:0][DIGIT-1:0]  r_a;
  logic [NDIG-1:0][DIGIT-1:0]  r_b;
  logic                        r_sgn;
  logic [IW-1:0]               r_idx;
  logic                        r_found;
  res_t                        r_res;
  logic                        r_eq;
  logic                        r_gt;
  logic                        r_lt;

  logic [DIGIT-1:0]            w_dx;
  logic [DIGIT-1:0]            w_dy;
  logic                        w_inv;
  logic                        w_deq;
  logic                        w_dgt;
  logic                        w_dlt;
  logic                        w_last;
  logic                        w_decide;
  res_t                        w_cur;
  res_t                        w_final;

  assign w_dx   = r_a[r_idx];
  assign w_dy   = r_b[r_idx];
  // Only the top digit carries the sign bit.
  assign w_inv  = r_sgn & (r_idx == IDX_TOP);
  assign w_last = (r_idx == '0);

  cmp_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x         (w_dx),
    .y         (w_dy),
    .invert_msb(w_inv),
    .eq        (w_deq),
    .gt        (w_dgt),
    .lt        (w_dlt)
  );

  always_comb begin
    w_cur = RES_EQ;
    if (w_dgt) begin
      w_cur = RES_GT;
    end else if (w_dlt) begin
      w_cur = RES_LT;
    end
  end

  // The first differing digit wins; later digits never override it.
  assign w_final  = r_found ? r_res : w_cur;
  assign w_decide = w_last | ((EARLY_EXIT != 0) & ~w_deq);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_decide) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_res   <= RES_EQ;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sgn   <= signed_mode;
            r_idx   <= IDX_TOP;
            r_found <= 1'b0;
          end
        end
        RUN: begin
          if (w_decide) begin
            r_eq <= (w_final == RES_EQ);
            r_gt <= (w_final == RES_GT);
            r_lt <= (w_final == RES_LT);
          end else begin
            r_idx <= r_idx - IW'(1);
            if (!w_deq && !r_found) begin
              r_found <= 1'b1;
              r_res   <= w_cur;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign a_is_equal   = r_eq;
  assign a_is_greater = r_gt;
  assign a_is_smaller = r_lt;

endmodule

// File: tb/tb_cmp_serial_param.sv
// Bench for cmp_serial_param: 16-bit early-exit and full-scan instances plus a 4-bit instance,
// compared against an integer-arithmetic reference of the comparison and its latency.
module tb_cmp_serial_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, sgn16;
  logic [15:0] a16, b16;
  logic        start4, sgn4;
  logic [3:0]  a4, b4;

  logic busy_e, done_e, eq_e, gt_e, lt_e;
  logic busy_f, done_f, eq_f, gt_f, lt_f;
  logic busy4, done4, eq4, gt4, lt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmp_serial_param #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sgn16), .a(a16), .b(b16),
    .busy(busy_e), .done(done_e), .a_is_equal(eq_e), .a_is_greater(gt_e), .a_is_smaller(lt_e)
  );

  cmp_serial_param #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sgn16), .a(a16), .b(b16),
    .busy(busy_f), .done(done_f), .a_is_equal(eq_f), .a_is_greater(gt_f), .a_is_smaller(lt_f)
  );

  cmp_serial_param #(.WIDTH(4), .DIGIT(4), .EARLY_EXIT(1)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sgn4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .a_is_equal(eq4), .a_is_greater(gt4), .a_is_smaller(lt4)
  );

  // Relation of x to y as plain integers: returns {gt, lt, eq}.
  function automatic logic [2:0] ref_flags(input logic [15:0] x, input logic [15:0] y, input bit sg);
    int xi, yi;
    xi = sg ? int'($signed(x)) : int'(x);
    yi = sg ? int'($signed(y)) : int'(y);
    if (xi > yi) return 3'b100;
    if (xi < yi) return 3'b010;
    return 3'b001;
  endfunction

  // Position (1 = top hex digit) of the first differing digit, or 4 when all match.
  function automatic int first_diff(input logic [15:0] x, input logic [15:0] y);
    for (int d = 3; d >= 0; d--) begin
      if (x[d*4 +: 4] != y[d*4 +: 4]) return 4 - d;
    end
    return 4;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v, input bit sg,
                       input bit chg, input int pulse_at);
    int ke, kf, ne, nf, nbusy, ek;
    logic [2:0] ef;
    ke = -1; kf = -1; ne = 0; nf = 0;
    ef = ref_flags(ta, tb_v, sg);
    ek = first_diff(ta, tb_v);
    start16 = 1'b1; a16 = ta; b16 = tb_v; sgn16 = sg;
    @(posedge clk); #1;
    start16 = 1'b0;
    nbusy = busy_e ? 1 : 0;
    if (chg) begin
      a16 = 16'hFFFF; b16 = 16'hFFFF;
    end
    for (int c = 1; c <= 12; c++) begin
      start16 = (c == pulse_at);
      @(posedge clk); #1;
      if (done_e) begin ne++; if (ke < 0) ke = c; end
      if (done_f) begin nf++; if (kf < 0) kf = c; end
      if (busy_e) nbusy++;
    end
    start16 = 1'b0;
    chk("early_latency", ke, ek);
    chk("early_done_count", ne, 1);
    chk("early_flags", {gt_e, lt_e, eq_e}, ef);
    chk("early_busy_cycles", nbusy, ek + 1);
    chk("full_latency", kf, 4);
    chk("full_done_count", nf, 1);
    chk("full_flags", {gt_f, lt_f, eq_f}, ef);
  endtask

  initial begin
    int ndone;
    logic [15:0] ra, rb;
    rst = 1'b1; start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_early", {busy_e, done_e, gt_e, lt_e, eq_e}, 0);
    chk("reset_full", {busy_f, done_f, gt_f, lt_f, eq_f}, 0);
    chk("reset_w4", {busy4, done4, gt4, lt4, eq4}, 0);
    rst = 1'b0;

    run16(16'h1234, 16'h1234, 1'b0, 1'b0, 0);
    run16(16'h8000, 16'h7FFF, 1'b0, 1'b0, 0);
    run16(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run16(16'h8000, 16'h7FFF, 1'b1, 1'b0, 0);
    run16(16'h00A5, 16'h00A6, 1'b0, 1'b1, 0);
    run16(16'h1234, 16'h1234, 1'b0, 1'b0, 2);

    // Abort in the second RUN cycle.
    start16 = 1'b1; a16 = 16'h5555; b16 = 16'h5555; sgn16 = 1'b0;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_early", {busy_e, done_e, gt_e, lt_e, eq_e}, 0);
    chk("abort_full", {busy_f, done_f, gt_f, lt_f, eq_f}, 0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done_e || done_f || busy_e || busy_f) ndone++;
    end
    chk("abort_no_activity", ndone, 0);

    run16(16'h0F00, 16'h0E00, 1'b0, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'h1 << $urandom_range(0, 15));
      endcase
      run16(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          logic [3:0] xv, yv;
          logic [2:0] ef;
          xv = x[3:0]; yv = y[3:0];
          ef = ref_flags({{12{m[0] & xv[3]}}, xv}, {{12{m[0] & yv[3]}}, yv}, m[0]);
          start4 = 1'b1; a4 = xv; b4 = yv; sgn4 = m[0];
          @(posedge clk); #1;
          start4 = 1'b0;
          @(posedge clk); #1;
          chk($sformatf("w4_m%0d_a%0d_b%0d", m, x, y), {done4, gt4, lt4, eq4}, {1'b1, ef});
          @(posedge clk); #1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
